bus_hold: RTL and testbench

Receiving end of the internal 6502 data/address bus. Samples the resolved bus value and driver enables on each bus phase, holds the last driven value when nothing drives the bus (open-bus charge retention), applies pull-downs to the held charge, and decays the held value after a programmable number of undriven samples. Optionally detects and counts driver contention for debug and verification. It sits after the bus resolver, feeding any block that reads the bus.

---
 rtl/bus_hold_if.sv | 23 ++
 rtl/bus_hold.sv | 80 ++++++++
 tb/tb_bus_hold.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/bus_hold_if.sv
// bus_hold_if: sampled bus, driver enables and held-charge outputs for bus_hold
interface bus_hold_if #(
  parameter int N = 4
) ();
  logic         sample_en;
  logic [7:0]   bus_value;
  logic [N-1:0] driver_enables;
  logic [7:0]   pull_down_enables;
  logic         contention_clr;
  logic [7:0]   hold_value;
  logic         open_bus;
  logic         decayed;
  logic         contention;
  logic [7:0]   contention_count;
  modport slave (
    input  sample_en, bus_value, driver_enables, pull_down_enables, contention_clr,
    output hold_value, open_bus, decayed, contention, contention_count
  );
  modport master (
    output sample_en, bus_value, driver_enables, pull_down_enables, contention_clr,
    input  hold_value, open_bus, decayed, contention, contention_count
  );
endinterface

// File: rtl/bus_hold.sv
// bus_hold: open-bus charge retention with pull-downs, decay and optional contention counting (BUS_HOLD_CONTENTION_EN)
module bus_hold #(
  parameter int         N            = 4,
  parameter int         DECAY_CYCLES = 1024,
  parameter logic [7:0] DECAY_VALUE  = 8'h00
) (
  input logic      clk,
  input logic      rst_n,
  bus_hold_if.slave bus
);
  localparam int CW = $clog2(DECAY_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DECAY_CYCLES);
  logic [N-1:0]  en;
  logic          se;
  logic          driven;
  logic          hit;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [7:0]    hold_q, hold_d;
  logic          open_q, open_d;
  logic          dec_q, dec_d;
  assign en     = bus.driver_enables;
  assign se     = bus.sample_en;
  assign driven = |en;
  // Next held charge: capture when driven, otherwise bleed through pull-downs and decay once the counter saturates
  always_comb begin
    cnt_inc = (cnt_q == CMAX) ? cnt_q : cnt_q + CW'(1);
    hit     = (cnt_q != CMAX) && (cnt_inc == CMAX);
    hold_d  = !se ? hold_q : driven ? bus.bus_value :
              hit ? (DECAY_VALUE & ~bus.pull_down_enables) : (hold_q & ~bus.pull_down_enables);
    open_d  = se ? !driven : open_q;
    dec_d   = !se ? dec_q : driven ? 1'b0 : (dec_q | hit);
    cnt_d   = !se ? cnt_q : driven ? '0 : cnt_inc;
  end
  // Held-charge state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= DECAY_VALUE;
      open_q <= 1'b1;
      dec_q  <= 1'b1;
      cnt_q  <= '0;
    end else begin
      hold_q <= hold_d;
      open_q <= open_d;
      dec_q  <= dec_d;
      cnt_q  <= cnt_d;
    end
  end
  assign bus.hold_value = hold_q;
  assign bus.open_bus   = open_q;
  assign bus.decayed    = dec_q;
`ifdef BUS_HOLD_CONTENTION_EN
  logic       ev;
  logic       flag_q, flag_d;
  logic [7:0] num_q, num_d;
  // A contention event in the same cycle as a clear wins and restarts the count at one
  always_comb begin
    ev     = se && ($countones(en) > 1);
    flag_d = ev | (flag_q & ~bus.contention_clr);
    num_d  = ev ? (bus.contention_clr ? 8'd1 : (num_q == 8'hFF) ? num_q : num_q + 8'd1) :
             bus.contention_clr ? 8'd0 : num_q;
  end
  // Contention flag and saturating counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= 1'b0;
      num_q  <= 8'd0;
    end else begin
      flag_q <= flag_d;
      num_q  <= num_d;
    end
  end
  assign bus.contention       = flag_q;
  assign bus.contention_count = num_q;
`else
  logic unused_clr;
  assign unused_clr           = bus.contention_clr;
  assign bus.contention       = 1'b0;
  assign bus.contention_count = 8'd0;
`endif
endmodule

// File: tb/tb_bus_hold.sv
// tb_bus_hold: directed and randomized checks of bus_hold against a behavioural model
module tb_bus_hold;
  localparam int N = 4;
  localparam int DC = 4;
  localparam logic [7:0] DV = 8'h00;
`ifdef BUS_HOLD_CONTENTION_EN
  localparam bit CEN = 1'b1;
`else
  localparam bit CEN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_fail = 0;
  bus_hold_if #(.N(N)) bus ();
  bus_hold #(.N(N), .DECAY_CYCLES(DC), .DECAY_VALUE(DV)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  logic [7:0] m_hold;
  logic       m_open, m_dec, m_flag;
  int         m_cnt, m_num;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hold = DV; m_open = 1; m_dec = 1; m_cnt = 0; m_flag = 0; m_num = 0;
    end else begin
      int pc;
      pc = $countones(bus.driver_enables);
      if (CEN && bus.sample_en && pc >= 2) begin
        m_flag = 1;
        m_num = bus.contention_clr ? 1 : (m_num < 255 ? m_num + 1 : 255);
      end else if (CEN && bus.contention_clr) begin
        m_flag = 0; m_num = 0;
      end
      if (bus.sample_en) begin
        if (pc > 0) begin
          m_hold = bus.bus_value; m_open = 0; m_dec = 0; m_cnt = 0;
        end else begin
          m_open = 1;
          if (m_cnt < DC) begin
            m_cnt++;
            if (m_cnt == DC) begin
              m_hold = DV & ~bus.pull_down_enables;
              m_dec = 1;
            end else m_hold = m_hold & ~bus.pull_down_enables;
          end else m_hold = m_hold & ~bus.pull_down_enables;
        end
      end
    end
  end
  always @(negedge clk) begin
    chk("hold_value", bus.hold_value, m_hold);
    chk("open_bus", bus.open_bus, m_open);
    chk("decayed", bus.decayed, m_dec);
    chk("contention", bus.contention, m_flag);
    chk("contention_count", bus.contention_count, m_num);
  end
  task automatic cyc(input logic se, input logic [7:0] bv, input logic [N-1:0] en,
                     input logic [7:0] pd, input logic clr);
    @(negedge clk);
    bus.sample_en = se; bus.bus_value = bv; bus.driver_enables = en;
    bus.pull_down_enables = pd; bus.contention_clr = clr;
    @(posedge clk);
    #1;
    bus.sample_en = 0; bus.contention_clr = 0;
  endtask
  initial begin
    bus.sample_en = 0; bus.bus_value = 0; bus.driver_enables = 0;
    bus.pull_down_enables = 0; bus.contention_clr = 0;
    #12;
    chk("rst_hold", bus.hold_value, 8'h00);
    chk("rst_open", bus.open_bus, 1);
    chk("rst_decayed", bus.decayed, 1);
    chk("rst_contention", bus.contention, 0);
    @(negedge clk) rst_n = 1;
    cyc(1, 8'hA5, 4'b0001, 8'h00, 0);
    chk("drive_a5", bus.hold_value, 8'hA5);
    chk("drive_open", bus.open_bus, 0);
    repeat (3) cyc(1, 8'h11, 4'b0000, 8'h00, 0);
    chk("hold_a5", bus.hold_value, 8'hA5);
    chk("hold_open", bus.open_bus, 1);
    chk("hold_decayed", bus.decayed, 0);
    cyc(1, 8'hFF, 4'b0010, 8'h00, 0);
    cyc(1, 8'h00, 4'b0000, 8'h0F, 0);
    chk("pulldown_f0", bus.hold_value, 8'hF0);
    cyc(1, 8'h3C, 4'b0100, 8'h00, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 8'h99, 4'b0000, 8'h00, 0);
      cyc(0, 8'h99, 4'b0000, 8'h00, 0);
    end
    chk("decay_3rd_hold", bus.hold_value, 8'h3C);
    chk("decay_3rd_dec", bus.decayed, 0);
    cyc(1, 8'h99, 4'b0000, 8'h00, 0);
    chk("decay_4th_hold", bus.hold_value, 8'h00);
    chk("decay_4th_dec", bus.decayed, 1);
    cyc(1, 8'h77, 4'b1000, 8'h00, 0);
    chk("recover_hold", bus.hold_value, 8'h77);
    chk("recover_dec", bus.decayed, 0);
`ifdef BUS_HOLD_CONTENTION_EN
    repeat (300) cyc(1, 8'h42, 4'b0011, 8'h00, 0);
    chk("cont_flag", bus.contention, 1);
    chk("cont_sat", bus.contention_count, 255);
    cyc(1, 8'h43, 4'b0101, 8'h00, 1);
    chk("clr_event_count", bus.contention_count, 1);
    chk("clr_event_flag", bus.contention, 1);
    cyc(1, 8'h44, 4'b0001, 8'h00, 1);
    chk("clr_count", bus.contention_count, 0);
    chk("clr_flag", bus.contention, 0);
`else
    for (int i = 0; i < 10; i++) cyc(1, 8'(8'h20 + i), 4'b1111, 8'h00, 1);
    chk("nocont_flag", bus.contention, 0);
    chk("nocont_count", bus.contention_count, 0);
    chk("nocont_hold", bus.hold_value, 8'h29);
`endif
    cyc(1, 8'h5A, 4'b0001, 8'h00, 0);
    chk("pre_reset_hold", bus.hold_value, 8'h5A);
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("async_rst_hold", bus.hold_value, 8'h00);
    chk("async_rst_open", bus.open_bus, 1);
    chk("async_rst_dec", bus.decayed, 1);
    chk("async_rst_cont", bus.contention, 0);
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 3000; i++) begin
      logic se, clr;
      logic [N-1:0] en;
      logic [7:0] pd;
      se  = $urandom_range(0, 9) < 7;
      en  = ($urandom_range(0, 2) == 0) ? '0 : N'($urandom);
      pd  = ($urandom_range(0, 3) == 0) ? 8'($urandom & $urandom) : 8'h00;
      clr = $urandom_range(0, 19) == 0;
      cyc(se, 8'($urandom), en, pd, clr);
    end
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
